pattern_seq_ctrl: RTL and testbench
===================================

PATTERN_SEQ_CTRL -- requirements
Module: pattern_seq_ctrl

Interface
REQ-001 Parameter: VW, default 11, width of the datapath input vector.
REQ-002 Parameter: RW, default 10, width of the datapath result vector.
REQ-003 Parameter: LAT, default 1, datapath latency in cycles; legal range 1..15.
REQ-004 blif_clk_net  in  1  sole clock; all state rising-edge.
REQ-005 blif_reset_net  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  3  per-requester request, bit i = requester i.
REQ-007 req_vec  in  3*VW  requester vectors; requester i at bits [i*VW +: VW].
REQ-008 req_ready  out  3  one-hot grant/accept, combinational.
REQ-009 dp_in  out  VW  registered vector driven to the shared pattern datapath.
REQ-010 dp_launch  out  1  one-cycle strobe: dp_in valid, datapath evaluation starts.
REQ-011 dp_out  in  RW  datapath result, sampled LAT cycles after dp_launch.
REQ-012 resp_valid  out  1  result available.
REQ-013 resp_id  out  2  requester index owning the result (0..2).
REQ-014 resp_data  out  RW  captured result.
REQ-015 resp_ready  in  1  consumer accepts result.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 txn_cnt  out  16  completed-transaction count.

Function
REQ-018 FSM states IDLE, LAUNCH, WAIT, RESP; exactly one transaction in flight.
REQ-019 Arbitration round-robin over 3 requesters; rr_ptr = highest-priority index, reset 0.
REQ-020 In IDLE, req_ready = one-hot of first set req_valid bit searching rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3); zero if none valid.
REQ-021 req_ready is 0 in LAUNCH, WAIT, RESP regardless of req_valid.
REQ-022 Acceptance = req_valid[i] & req_ready[i]: dp_in <= req_vec slice i, resp_id <= i, rr_ptr <= (i+1) mod 3, state -> LAUNCH.
REQ-023 Requester dropping req_valid before acceptance: no grant, no state change; no penalty.
REQ-024 LAUNCH: dp_launch = 1 for exactly this cycle; 4-bit wait counter <= LAT-1; state -> WAIT.
REQ-025 WAIT: counter decrements each cycle; when counter = 0, resp_data <= dp_out, state -> RESP.
REQ-026 Net latency: dp_out sampled on the edge LAT cycles after the dp_launch edge; acceptance to resp_valid = LAT+2 cycles.
REQ-027 RESP: resp_valid = 1, resp_data and resp_id held stable until resp_valid & resp_ready.
REQ-028 On RESP handshake: state -> IDLE, txn_cnt += 1 (wraps 0xFFFF -> 0x0000).
REQ-029 New request during RESP handshake cycle: not accepted; granted earliest the following IDLE cycle (one-cycle bubble).
REQ-030 resp_ready asserted outside RESP: ignored.
REQ-031 dp_in holds last accepted vector until next acceptance.
REQ-032 Outputs resp_valid, dp_launch, busy registered-state decodes; no combinational path from dp_out to any output.

Reset
REQ-033 blif_reset_net low asynchronously forces: state IDLE, rr_ptr 0, counter 0, dp_in 0, resp_id 0, resp_data 0, txn_cnt 0; hence dp_launch 0, resp_valid 0, busy 0.
REQ-034 Reset during LAUNCH/WAIT/RESP: in-flight transaction discarded, txn_cnt not incremented, no resp_valid after release.
REQ-035 First grant permitted on the first rising edge after blif_reset_net deasserts.

Verification
REQ-036 LAT=1, req_valid=3'b001, req_vec[0]=11'h155, dp_out model = 10'h2AA -> req_ready=001 cycle 0, dp_launch cycle 1, resp_valid cycle 3, resp_id 0, resp_data 10'h2AA, txn_cnt 1 after handshake.
REQ-037 req_valid=3'b111 held, resp_ready=1 -> grant order 0,1,2,0,1,2; txn_cnt=6 after six responses.
REQ-038 LAT=4, single request, resp_ready=0 for 5 cycles after resp_valid -> resp_valid and resp_data stable 5 cycles, req_ready=000 throughout, then IDLE.
REQ-039 Reset asserted in WAIT (LAT=3, second cycle) -> busy 0 immediately, rr_ptr 0, no resp_valid after release, txn_cnt 0.
REQ-040 txn_cnt preloaded to 0xFFFF via 65535 transactions (or force) -> next completion gives 0x0000.
REQ-041 Requester 2 asserts req_valid in the RESP handshake cycle -> req_ready[2] not asserted that cycle; asserted the next cycle.

Source files
------------

// File: rtl/pattern_seq_ctrl.sv
`timescale 1ns/1ps
// pattern_seq_ctrl
//   Round-robin front end for a shared multi-cycle pattern datapath. Three
//   requesters compete for the datapath. One transaction is in flight at a time.
//   The winning vector is registered onto dp_in and launched. The result is
//   captured LAT cycles later and held until the consumer accepts it.
//
// Ports
//   blif_clk_net    in   clock, all state on the rising edge
//   blif_reset_net  in   asynchronous active-low reset
//   req_valid       in   [2:0] per-requester request
//   req_vec         in   [3*VW-1:0] requester vectors, requester i at [i*VW +: VW]
//   req_ready       out  [2:0] one-hot grant, combinational, only in IDLE
//   dp_in           out  [VW-1:0] registered vector to the datapath
//   dp_launch       out  one-cycle launch strobe
//   dp_out          in   [RW-1:0] datapath result
//   resp_valid      out  result available
//   resp_id         out  [1:0] requester owning the result
//   resp_data       out  [RW-1:0] captured result
//   resp_ready      in   consumer accepts result
//   busy            out  high whenever not IDLE
//   txn_cnt         out  [15:0] completed-transaction count, wraps
module pattern_seq_ctrl #(
    parameter int unsigned VW  = 11,
    parameter int unsigned RW  = 10,
    parameter int unsigned LAT = 1    // legal range 1..15
) (
    input  logic            blif_clk_net,
    input  logic            blif_reset_net,
    input  logic [2:0]      req_valid,
    input  logic [3*VW-1:0] req_vec,
    output logic [2:0]      req_ready,
    output logic [VW-1:0]   dp_in,
    output logic            dp_launch,
    input  logic [RW-1:0]   dp_out,
    output logic            resp_valid,
    output logic [1:0]      resp_id,
    output logic [RW-1:0]   resp_data,
    input  logic            resp_ready,
    output logic            busy,
    output logic [15:0]     txn_cnt
);

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

    localparam logic [3:0] LatM1 = 4'(LAT - 1);

    state_e          state_q, state_d;
    logic [1:0]      rr_ptr_q;
    logic [3:0]      cnt_q;
    logic [VW-1:0]   dp_in_q;
    logic [1:0]      resp_id_q;
    logic [RW-1:0]   resp_data_q;
    logic [15:0]     txn_cnt_q;

    logic [2:0]      grant;
    logic [1:0]      grant_idx;
    logic [1:0]      cand;
    logic            found;
    logic            accept;

    // Modulo-3 reduction of a value in 0..5.
    function automatic logic [1:0] wrap3(input logic [2:0] v);
        if (v >= 3'd3) begin
            return 2'(v - 3'd3);
        end
        return v[1:0];
    endfunction

    // Round-robin search starting at rr_ptr; grants only while idle.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        if (state_q == StIdle) begin
            for (int k = 0; k < 3; k++) begin
                cand = wrap3({1'b0, rr_ptr_q} + 3'(k));
                if (!found && req_valid[cand]) begin
                    grant[cand] = 1'b1;
                    grant_idx   = cand;
                    found       = 1'b1;
                end
            end
        end
    end

    assign accept = |grant;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (accept)          state_d = StLaunch;
            StLaunch:                      state_d = StWait;
            StWait:   if (cnt_q == 4'd0)   state_d = StResp;
            StResp:   if (resp_ready)      state_d = StIdle;
            default:                       state_d = StIdle;
        endcase
    end

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            dp_in_q     <= '0;
            resp_id_q   <= '0;
            resp_data_q <= '0;
            txn_cnt_q   <= '0;
        end else begin
            if (accept) begin
                dp_in_q   <= req_vec[grant_idx*VW +: VW];
                resp_id_q <= grant_idx;
                rr_ptr_q  <= wrap3({1'b0, grant_idx} + 3'd1);
            end
            if (state_q == StLaunch) begin
                cnt_q <= LatM1;
            end
            // Counter reaching zero marks the edge LAT cycles after launch.
            if (state_q == StWait) begin
                if (cnt_q != 4'd0) begin
                    cnt_q <= cnt_q - 4'd1;
                end else begin
                    resp_data_q <= dp_out;
                end
            end
            if (state_q == StResp && resp_ready) begin
                txn_cnt_q <= txn_cnt_q + 16'd1;
            end
        end
    end

    assign req_ready  = grant;
    assign dp_in      = dp_in_q;
    assign dp_launch  = (state_q == StLaunch);
    assign resp_valid = (state_q == StResp);
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign busy       = (state_q != StIdle);
    assign txn_cnt    = txn_cnt_q;

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
`timescale 1ns/1ps
// Directed bench for pattern_seq_ctrl. Three instances share all inputs and
// differ only in LAT: index 0 -> LAT=1, index 1 -> LAT=4, index 2 -> LAT=3.
module tb_pattern_seq_ctrl;

    localparam int unsigned VW = 11;
    localparam int unsigned RW = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [2:0]      req_valid = '0;
    logic [3*VW-1:0] req_vec = '0;
    logic [RW-1:0]   dp_out = '0;
    logic            resp_ready = 1'b0;

    logic [2:0]      req_ready_w  [3];
    logic [VW-1:0]   dp_in_w      [3];
    logic            dp_launch_w  [3];
    logic            resp_valid_w [3];
    logic [1:0]      resp_id_w    [3];
    logic [RW-1:0]   resp_data_w  [3];
    logic            busy_w       [3];
    logic [15:0]     txn_cnt_w    [3];

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 1 : ((g == 1) ? 4 : 3);
        pattern_seq_ctrl #(.VW(VW), .RW(RW), .LAT(L)) u_dut (
            .blif_clk_net   (clk),
            .blif_reset_net (rst_n),
            .req_valid      (req_valid),
            .req_vec        (req_vec),
            .req_ready      (req_ready_w[g]),
            .dp_in          (dp_in_w[g]),
            .dp_launch      (dp_launch_w[g]),
            .dp_out         (dp_out),
            .resp_valid     (resp_valid_w[g]),
            .resp_id        (resp_id_w[g]),
            .resp_data      (resp_data_w[g]),
            .resp_ready     (resp_ready),
            .busy           (busy_w[g]),
            .txn_cnt        (txn_cnt_w[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic wait_resp(input int idx, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (resp_valid_w[idx]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        chk_cnt++;
        if (busy_w[0] !== 1'b0) $display("FAIL reset_busy: got %0h expected 0", busy_w[0]);
        else pass_cnt++;
        chk_cnt++;
        if (resp_valid_w[0] !== 1'b0) $display("FAIL reset_resp_valid: got %0h expected 0", resp_valid_w[0]);
        else pass_cnt++;
        chk_cnt++;
        if (dp_launch_w[0] !== 1'b0) $display("FAIL reset_dp_launch: got %0h expected 0", dp_launch_w[0]);
        else pass_cnt++;
        chk_cnt++;
        if (txn_cnt_w[0] !== 16'h0) $display("FAIL reset_txn_cnt: got %0h expected 0", txn_cnt_w[0]);
        else pass_cnt++;
        chk_cnt++;
        if (dp_in_w[0] !== 11'h0) $display("FAIL reset_dp_in: got %0h expected 0", dp_in_w[0]);
        else pass_cnt++;
        chk_cnt++;
        if (resp_data_w[0] !== 10'h0 || resp_id_w[0] !== 2'd0)
            $display("FAIL reset_resp_regs: got data %0h id %0h expected 0 0", resp_data_w[0], resp_id_w[0]);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_basic();
        do_reset();
        req_vec        = '0;
        req_vec[10:0]  = 11'h155;
        dp_out         = 10'h2AA;
        req_valid      = 3'b001;
        #1;
        chk_cnt++;
        if (req_ready_w[0] !== 3'b001) $display("FAIL basic_grant: got %b expected 001", req_ready_w[0]);
        else pass_cnt++;
        tick();
        req_valid = '0;
        chk_cnt++;
        if (dp_launch_w[0] !== 1'b1 || dp_in_w[0] !== 11'h155)
            $display("FAIL basic_launch: got launch %0h dp_in %0h expected 1 155", dp_launch_w[0], dp_in_w[0]);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({dp_launch_w[0], resp_valid_w[0]} !== 2'b00)
            $display("FAIL basic_wait: got launch/valid %b expected 00", {dp_launch_w[0], resp_valid_w[0]});
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (resp_valid_w[0] !== 1'b1 || resp_id_w[0] !== 2'd0 || resp_data_w[0] !== 10'h2AA)
            $display("FAIL basic_resp: got valid %0h id %0h data %0h expected 1 0 2aa",
                     resp_valid_w[0], resp_id_w[0], resp_data_w[0]);
        else pass_cnt++;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk_cnt++;
        if (resp_valid_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || txn_cnt_w[0] !== 16'd1)
            $display("FAIL basic_done: got valid %0h busy %0h cnt %0h expected 0 0 1",
                     resp_valid_w[0], busy_w[0], txn_cnt_w[0]);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_gnt [6];
        int n;
        exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        n = 0;
        do_reset();
        req_vec    = {11'h333, 11'h222, 11'h111};
        dp_out     = 10'h0F0;
        req_valid  = 3'b111;
        resp_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && n < 6; cyc++) begin
            #1;
            if (req_ready_w[0] != 3'b000) begin
                chk_cnt++;
                if (req_ready_w[0] !== exp_gnt[n])
                    $display("FAIL rr_order_%0d: got %b expected %b", n, req_ready_w[0], exp_gnt[n]);
                else pass_cnt++;
                n++;
            end
            if (n < 6) tick();
        end
        tick();
        req_valid = '0;
        chk_cnt++;
        if (n != 6) $display("FAIL rr_timeout: got %0d grants expected 6", n);
        else pass_cnt++;
        for (int c = 0; c < 50 && busy_w[0]; c++) tick();
        resp_ready = 1'b0;
        chk_cnt++;
        if (txn_cnt_w[0] !== 16'd6) $display("FAIL rr_txn_cnt: got %0d expected 6", txn_cnt_w[0]);
        else pass_cnt++;
    endtask

    task automatic test_hold();
        int lat;
        int bad;
        bad = 0;
        do_reset();
        req_vec         = '0;
        req_vec[21:11]  = 11'h3C3;
        dp_out          = 10'h1B6;
        req_valid       = 3'b010;
        #1;
        chk_cnt++;
        if (req_ready_w[1] !== 3'b010) $display("FAIL hold_grant: got %b expected 010", req_ready_w[1]);
        else pass_cnt++;
        tick();
        req_valid = 3'b111;
        #1;
        lat = 1;
        while (!resp_valid_w[1] && lat < 20) begin
            if (req_ready_w[1] !== 3'b000) bad++;
            tick();
            #1;
            lat++;
        end
        chk_cnt++;
        if (lat != 6) $display("FAIL hold_latency: got %0d cycles expected 6", lat);
        else pass_cnt++;
        dp_out = 10'h000;
        for (int k = 0; k < 5; k++) begin
            chk_cnt++;
            if (resp_valid_w[1] !== 1'b1 || resp_data_w[1] !== 10'h1B6 || resp_id_w[1] !== 2'd1 ||
                req_ready_w[1] !== 3'b000)
                $display("FAIL hold_stable_%0d: got valid %0h data %0h id %0h ready %b expected 1 1b6 1 000",
                         k, resp_valid_w[1], resp_data_w[1], resp_id_w[1], req_ready_w[1]);
            else pass_cnt++;
            tick();
        end
        chk_cnt++;
        if (bad != 0) $display("FAIL hold_no_grant_busy: got %0d grants expected 0", bad);
        else pass_cnt++;
        req_valid  = '0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk_cnt++;
        if (busy_w[1] !== 1'b0 || txn_cnt_w[1] !== 16'd1)
            $display("FAIL hold_done: got busy %0h cnt %0h expected 0 1", busy_w[1], txn_cnt_w[1]);
        else pass_cnt++;
    endtask

    task automatic test_reset_in_wait();
        int seen;
        seen = 0;
        do_reset();
        req_vec        = '0;
        req_vec[10:0]  = 11'h0AB;
        dp_out         = 10'h155;
        req_valid      = 3'b001;
        #1;
        tick();
        req_valid = '0;
        tick();
        tick();
        chk_cnt++;
        if (busy_w[2] !== 1'b1) $display("FAIL rstwait_busy_before: got %0h expected 1", busy_w[2]);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (busy_w[2] !== 1'b0 || resp_valid_w[2] !== 1'b0)
            $display("FAIL rstwait_async: got busy %0h valid %0h expected 0 0", busy_w[2], resp_valid_w[2]);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (resp_valid_w[2]) seen++;
            tick();
        end
        chk_cnt++;
        if (seen != 0 || txn_cnt_w[2] !== 16'd0)
            $display("FAIL rstwait_discard: got valid cycles %0d cnt %0h expected 0 0", seen, txn_cnt_w[2]);
        else pass_cnt++;
        req_valid = 3'b111;
        #1;
        chk_cnt++;
        if (req_ready_w[2] !== 3'b001) $display("FAIL rstwait_rr_ptr: got %b expected 001", req_ready_w[2]);
        else pass_cnt++;
        req_valid = '0;
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        @(negedge clk);
        force g_dut[0].u_dut.txn_cnt_q = 16'hFFFF;
        #1;
        release g_dut[0].u_dut.txn_cnt_q;
        #1;
        chk_cnt++;
        if (txn_cnt_w[0] !== 16'hFFFF) $display("FAIL wrap_preload: got %0h expected ffff", txn_cnt_w[0]);
        else pass_cnt++;
        req_vec        = '0;
        req_vec[10:0]  = 11'h7FF;
        req_valid      = 3'b001;
        tick();
        req_valid = '0;
        wait_resp(0, ok);
        chk_cnt++;
        if (!ok) $display("FAIL wrap_timeout: got no resp_valid expected resp_valid");
        else pass_cnt++;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk_cnt++;
        if (txn_cnt_w[0] !== 16'h0000) $display("FAIL wrap_count: got %0h expected 0", txn_cnt_w[0]);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        req_vec   = {11'h2D2, 11'h000, 11'h04C};
        dp_out    = 10'h3C3;
        req_valid = 3'b001;
        tick();
        req_valid = '0;
        wait_resp(0, ok);
        chk_cnt++;
        if (!ok) $display("FAIL b2b_timeout: got no resp_valid expected resp_valid");
        else pass_cnt++;
        resp_ready = 1'b1;
        req_valid  = 3'b100;
        #1;
        chk_cnt++;
        if (req_ready_w[0][2] !== 1'b0) $display("FAIL b2b_no_grant_in_resp: got %b expected 0", req_ready_w[0][2]);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (req_ready_w[0] !== 3'b100 || txn_cnt_w[0] !== 16'd1)
            $display("FAIL b2b_grant_next: got ready %b cnt %0h expected 100 1", req_ready_w[0], txn_cnt_w[0]);
        else pass_cnt++;
        tick();
        req_valid = '0;
        chk_cnt++;
        if (dp_launch_w[0] !== 1'b1 || dp_in_w[0] !== 11'h2D2 || resp_id_w[0] !== 2'd2 || txn_cnt_w[0] !== 16'd1)
            $display("FAIL b2b_launch: got launch %0h dp_in %0h id %0h cnt %0h expected 1 2d2 2 1",
                     dp_launch_w[0], dp_in_w[0], resp_id_w[0], txn_cnt_w[0]);
        else pass_cnt++;
        resp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_hold();
        test_reset_in_wait();
        test_wrap();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
